// File: rtl/alu_exec_unit.sv
// Execute-stage ALU for the 8-bit pipelined MIPS datapath: single-cycle ops plus
// an iterative shift-add MUL, with valid/ready handshakes on both sides.
module alu_exec_unit #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        alu_ctrl,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              ovf
);
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam int MSB   = DATA_W - 1;

    typedef enum logic {IDLE, MUL_BUSY} state_t;

    state_t            state, state_next;
    logic [DATA_W-1:0] mcand, mplier, acc;
    logic [CNT_W-1:0]  cnt;
    logic              accept, is_mul, mul_done;
    logic [DATA_W-1:0] alu_res, acc_step, sum, diff;
    logic              alu_ovf;

    assign is_mul   = (alu_ctrl == 3'b101);
    assign in_ready = (state == IDLE) && (!out_valid || out_ready) && !flush;
    assign accept   = in_valid && in_ready;
    assign acc_step = mplier[0] ? acc + mcand : acc;
    assign mul_done = (state == MUL_BUSY) && (cnt == CNT_W'(DATA_W - 1));

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        sum     = op_a + op_b;
        diff    = op_a - op_b;
        case (alu_ctrl)
            3'b000: begin
                alu_res = sum;
                alu_ovf = (op_a[MSB] == op_b[MSB]) && (sum[MSB] != op_a[MSB]);
            end
            3'b001: begin
                alu_res = diff;
                alu_ovf = (op_a[MSB] != op_b[MSB]) && (diff[MSB] != op_a[MSB]);
            end
            3'b010:  alu_res = op_a & op_b;
            3'b011:  alu_res = op_a | op_b;
            3'b100:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            3'b110:  alu_res = op_a << op_b[2:0];
            3'b111:  alu_res = op_a >> op_b[2:0];
            default: alu_res = '0;   // MUL result comes from the accumulator
        endcase
    end

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:     if (accept && is_mul) state_next = MUL_BUSY;
                MUL_BUSY: if (mul_done) state_next = IDLE;
                default:  state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            cnt       <= '0;
            result    <= '0;
            zero      <= 1'b1;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else if (flush) begin
            // Squash: drop any pending result, leave result bits as they were.
            cnt       <= '0;
            out_valid <= 1'b0;
        end else begin
            if (accept && is_mul) begin
                mcand  <= op_a;
                mplier <= op_b;
                acc    <= '0;
                cnt    <= '0;
            end else if (state == MUL_BUSY) begin
                acc    <= acc_step;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + 1'b1;
            end

            if (accept && !is_mul) begin
                result    <= alu_res;
                zero      <= (alu_res == '0);
                ovf       <= alu_ovf;
                out_valid <= 1'b1;
            end else if (mul_done) begin
                result    <= acc_step;
                zero      <= (acc_step == '0);
                ovf       <= 1'b0;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit; inputs change and outputs are
// sampled 1 ns after each rising edge.
module tb_alu_exec_unit;
    logic       clk = 1'b0;
    logic       rst_n, flush, in_valid, in_ready, out_valid, out_ready, zero, ovf;
    logic [2:0] alu_ctrl;
    logic [7:0] op_a, op_b, result;
    int         checks = 0;
    int         errors = 0;

    alu_exec_unit #(.DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
        .in_ready(in_ready), .alu_ctrl(alu_ctrl), .op_a(op_a), .op_b(op_b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .zero(zero), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [2:0] c, input logic [7:0] a, input logic [7:0] b);
        in_valid = 1'b1;
        alu_ctrl = c;
        op_a     = a;
        op_b     = b;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        alu_ctrl = 3'b000; op_a = 8'h00; op_b = 8'h00;
        step(); step();
        checks++;
        if (out_valid !== 1'b0 || result !== 8'h00 || zero !== 1'b1 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: ov=%b res=%h z=%b ovf=%b, need 0 00 1 0", out_valid, result, zero, ovf);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b need 1", in_ready);
        end
        $display("reset: initial state checked");
        // leave a nonzero result behind, then reset in the middle of a MUL
        set_op(3'b000, 8'h02, 8'h03);
        step();
        set_op(3'b101, 8'h0D, 8'h0B);
        step();
        in_valid = 1'b0;
        step(); step(); step();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || result !== 8'h00 || zero !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_mul: ov=%b res=%h z=%b, need 0 00 1", out_valid, result, zero);
        end
        step();
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_mul_in_ready: got %b need 1", in_ready);
        end
        for (int i = 0; i < 10; i++) step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort_no_result: out_valid %b need 0", out_valid);
        end
        $display("reset: mid-MUL reset checked");
    endtask

    task automatic test_single_cycle();
        logic [2:0] c_t [8] = '{3'b000, 3'b001, 3'b100, 3'b110, 3'b111, 3'b010, 3'b011, 3'b001};
        logic [7:0] a_t [8] = '{8'h7F, 8'h05, 8'hFF, 8'h81, 8'h80, 8'hF0, 8'hF0, 8'h80};
        logic [7:0] b_t [8] = '{8'h01, 8'h05, 8'h01, 8'h0B, 8'h07, 8'h3C, 8'h0F, 8'h01};
        logic [7:0] r_t [8] = '{8'h80, 8'h00, 8'h01, 8'h08, 8'h01, 8'h30, 8'hFF, 8'h7F};
        logic       o_t [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            set_op(c_t[i], a_t[i], b_t[i]);
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL op%0d_in_ready: got %b need 1", i, in_ready);
            end
            step();
            checks++;
            if (out_valid !== 1'b1 || result !== r_t[i] || zero !== (r_t[i] == 8'h00) || ovf !== o_t[i]) begin
                errors++;
                $display("FAIL op%0d ctrl=%b a=%h b=%h: ov=%b res=%h z=%b ovf=%b, need 1 %h %b %b",
                         i, c_t[i], a_t[i], b_t[i], out_valid, result, zero, ovf,
                         r_t[i], (r_t[i] == 8'h00), o_t[i]);
            end
            $display("op ctrl=%b a=%h b=%h -> res=%h ovf=%b", c_t[i], a_t[i], b_t[i], result, ovf);
        end
        in_valid = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_out_valid: got %b need 0", out_valid);
        end
    endtask

    task automatic test_mul(input logic [7:0] a, input logic [7:0] b, input logic [7:0] exp_r);
        out_ready = 1'b1;
        set_op(3'b101, a, b);
        step();
        in_valid = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL mul_in_ready_busy step%0d: got %b need 0", i, in_ready);
            end
            step();
            if (i < 8) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL mul_early_valid step%0d: got %b need 0", i, out_valid);
                end
            end
        end
        checks++;
        if (out_valid !== 1'b1 || result !== exp_r || zero !== (exp_r == 8'h00) || ovf !== 1'b0) begin
            errors++;
            $display("FAIL mul %h*%h: ov=%b res=%h z=%b ovf=%b, need 1 %h %b 0",
                     a, b, out_valid, result, zero, ovf, exp_r, (exp_r == 8'h00));
        end
        $display("mul %h*%h -> res=%h zero=%b", a, b, result, zero);
        step();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        set_op(3'b000, 8'h01, 8'h02);
        step();
        set_op(3'b011, 8'h0F, 8'h30);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid !== 1'b1 || result !== 8'h03 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL backpressure_hold%0d: ov=%b res=%h in_ready=%b, need 1 03 0", i, out_valid, result, in_ready);
            end
            step();
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_release_in_ready: got %b need 1", in_ready);
        end
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || result !== 8'h3F) begin
            errors++;
            $display("FAIL backpressure_next_op: ov=%b res=%h, need 1 3f", out_valid, result);
        end
        $display("backpressure: released, res=%h", result);
        step();
    endtask

    task automatic test_flush();
        out_ready = 1'b1;
        set_op(3'b101, 8'h0D, 8'h0B);
        step();
        in_valid = 1'b0;
        step(); step(); step();
        flush = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_in_ready: got %b need 0", in_ready);
        end
        step();
        flush = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_idle: ov=%b in_ready=%b, need 0 1", out_valid, in_ready);
        end
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush_no_result cycle%0d: ov=%b need 0", i, out_valid);
            end
        end
        set_op(3'b000, 8'h02, 8'h03);
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || result !== 8'h05 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL flush_then_add: ov=%b res=%h ovf=%b, need 1 05 0", out_valid, result, ovf);
        end
        $display("flush: following add res=%h", result);
        step();
    endtask

    initial begin
        test_reset();
        test_single_cycle();
        test_mul(8'h0D, 8'h0B, 8'h8F);
        test_mul(8'h10, 8'h10, 8'h00);
        test_backpressure();
        test_flush();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Execute-stage arithmetic unit of the 8-bit pipelined MIPS datapath. Sits directly downstream of the ALU operand-2 selector: takes operand A from the ID/EX register and operand B from the selector output, performs the operation named by `alu_ctrl`, and registers the result for the EX/MEM stage. Single-cycle ops complete in one cycle. MUL runs an iterative 8-step shift-add and back-pressures the pipeline through a valid/ready handshake.

## Interface
- `DATA_W`, 8, operand/result width (MUL step count equals `DATA_W`)
- `clk` input 1 rising-edge clock
- `rst_n` input 1 asynchronous active-low reset
- `flush` input 1 synchronous kill of in-flight op and pending result (branch/hazard squash)
- `in_valid` input 1 upstream presents an operation
- `in_ready` output 1 unit accepts an operation this cycle
- `alu_ctrl` input 3 000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLT (signed), 101 MUL (low byte), 110 SLL, 111 SRL
- `op_a` input DATA_W first operand
- `op_b` input DATA_W second operand (operand-2 selector output)
- `out_valid` output 1 `result`/flags hold a completed operation
- `out_ready` input 1 downstream consumes the result this cycle
- `result` output DATA_W registered result
- `zero` output 1 registered, `result == 0`
- `ovf` output 1 registered signed overflow (ADD/SUB only, else 0)

## Operation
- Transfer in: `in_valid && in_ready` at a rising edge. Transfer out: `out_valid && out_ready`.
- States: IDLE, MUL_BUSY.
- `in_ready = (state == IDLE) && (!out_valid || out_ready) && !flush`.
- IDLE, accept non-MUL: compute combinationally; register `result`, `zero`, `ovf`; `out_valid <= 1`. Stay in IDLE.
- IDLE, accept MUL: latch multiplicand = `op_a`, multiplier = `op_b`, clear accumulator and step counter; go to MUL_BUSY. `out_valid` is cleared if the old result is consumed the same edge.
- MUL_BUSY, each cycle: if multiplier LSB is 1, acc += multiplicand (mod 2^DATA_W). Multiplicand shifts left 1, multiplier shifts right 1, counter increments. After step DATA_W: `result <= acc`, `zero` computed, `ovf <= 0`, `out_valid <= 1`, go to IDLE.
- Arithmetic is mod 2^DATA_W. ADD `ovf` = operands same sign and result sign differs. SUB `ovf` = operands differ in sign and result sign differs from `op_a`.
- SLT: result = 1 if `$signed(op_a) < $signed(op_b)`, else 0.
- SLL/SRL: shift amount `op_b[2:0]`, logical, zero fill.
- `out_valid` clears on an output transfer unless a new result is loaded the same edge.
- `flush` (sync, highest priority after reset): state <= IDLE, `out_valid <= 0`, no input accepted that cycle. `result` is left unchanged.

## Timing
- Reset (async, `rst_n` = 0): state IDLE, `out_valid` 0, `result` 0, `zero` 1, `ovf` 0, counter 0. `in_ready` is 1 once `rst_n` = 1.
- Non-MUL latency: accept at edge N, `out_valid` = 1 after edge N.
- MUL latency: accept at edge N, steps at edges N+1..N+DATA_W, `out_valid` = 1 after edge N+DATA_W. `in_ready` = 0 from edge N until the result is consumed or the unit returns to IDLE with the output slot free.
- Back-to-back non-MUL with `out_ready` held 1: one op per cycle, no bubbles.
- Result held stable while `out_valid && !out_ready`. `in_ready` is then 0.
- Reset or flush mid-MUL aborts the op. No result is ever produced for it.

## Test plan
- Reset: assert `rst_n` = 0 mid-MUL -> `out_valid` 0, `result` 0, `zero` 1, `in_ready` 1 after release.
- ADD 0x7F + 0x01 -> `result` 0x80, `ovf` 1, one cycle. SUB 0x05 - 0x05 -> `result` 0x00, `zero` 1, `ovf` 0.
- SLT 0xFF vs 0x01 -> 1. SLL 0x81 by `op_b` 0x0B (amount 3) -> 0x08. SRL 0x80 by 7 -> 0x01.
- MUL 0x0D x 0x0B -> 0x8F, `out_valid` exactly 8 cycles after accept, `in_ready` 0 throughout. MUL 0x10 x 0x10 -> 0x00, `zero` 1.
- Back-pressure: hold `out_ready` 0 with a result pending -> `result` stable, `in_ready` 0. Release -> next op accepted the same edge as the transfer.
- Flush at MUL step 4 -> state IDLE, `out_valid` stays 0. A following ADD 0x02 + 0x03 -> 0x05 with normal one-cycle latency.
